// File: rtl/serdes_lb_pkg.sv
// rtl/serdes_lb_pkg.sv - shared constants, lock state and saturating add for the SERDES loopback checker
package serdes_lb_pkg;

    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    localparam logic [7:0] D10_2_BYTE = 8'h4A;

    typedef enum logic [1:0] {
        UNLOCKED,
        VERIFY,
        LOCKED
    } lock_state_t;

    localparam int SAT_W = 64;

    // Callers zero-extend to SAT_W and pass their own all-ones limit; a must not exceed lim.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] lim
    );
        return (b > (lim - a)) ? lim : (a + b);
    endfunction

endpackage

// File: rtl/serdes_lane_cmp.sv
// rtl/serdes_lane_cmp.sv - one byte lane checked against the K28.5 / D10.2 comma pattern
module serdes_lane_cmp
    import serdes_lb_pkg::*;
(
    input  logic [7:0] data,
    input  logic       is_k,
    input  logic       not_in_table,
    input  logic       disp_err,
    input  logic       is_comma_lane,
    output logic       lane_bad
);

    logic [7:0] exp_data;

    assign exp_data = is_comma_lane ? K28_5_BYTE : D10_2_BYTE;
    assign lane_bad = (data != exp_data) | (is_k != is_comma_lane) | not_in_table | disp_err;

endmodule

// File: rtl/serdes_rx_checker.sv
// rtl/serdes_rx_checker.sv - RX comma-pattern lock FSM with saturating word/lane error counters
module serdes_rx_checker
    import serdes_lb_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_BAD  = 4,
    parameter int CNT_W     = 32
) (
    input  logic                     rx_clk,
    input  logic                     rst,
    input  logic [8*LANES-1:0]       rx_data_i,
    input  logic [LANES-1:0]         rx_char_is_k_i,
    input  logic [LANES-1:0]         rx_not_in_table_i,
    input  logic [LANES-1:0]         rx_disp_err_i,
    input  logic                     rx_byte_is_aligned_i,
    input  logic                     cnt_reset_i,
    output logic                     locked_o,
    output logic [$clog2(LANES)-1:0] k_pos_o,
    output logic                     err_o,
    output logic [CNT_W-1:0]         word_err_cnt_o,
    output logic [CNT_W-1:0]         lane_err_cnt_o
);

    localparam int KP_W = $clog2(LANES);
    localparam int NB_W = $clog2(LANES + 1);
    localparam int GC_W = $clog2(LOCK_GOOD + 1);
    localparam int BC_W = $clog2(LOSS_BAD + 1);

    localparam logic [GC_W-1:0]  GOOD_LAST = GC_W'(LOCK_GOOD - 1);
    localparam logic [BC_W-1:0]  BAD_LAST  = BC_W'(LOSS_BAD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [8*LANES-1:0] s1_data, s2_data;
    logic [LANES-1:0]   s1_k, s2_k, s1_nit, s2_nit, s1_de, s2_de;
    logic               s1_al, s2_al;

    lock_state_t       state, state_n;
    logic [GC_W-1:0]   good_cnt, good_n;
    logic [BC_W-1:0]   bad_cnt, bad_n;
    logic [KP_W-1:0]   k_pos, k_pos_n, k_idx, cmp_lane;
    logic [NB_W-1:0]   k_ones, lane_bad_n;
    logic [LANES-1:0]  lane_bad;
    logic              word_bad, candidate, count_en, err_n;
    logic [CNT_W-1:0]  word_cnt, lane_cnt;

    // Two register stages so the compare runs in the same cycle the FSM updates,
    // which lets the word right after a candidate see the freshly captured k_pos.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            s1_data <= '0;
            s1_k    <= '0;
            s1_nit  <= '0;
            s1_de   <= '0;
            s1_al   <= 1'b0;
            s2_data <= '0;
            s2_k    <= '0;
            s2_nit  <= '0;
            s2_de   <= '0;
            s2_al   <= 1'b0;
        end else begin
            s1_data <= rx_data_i;
            s1_k    <= rx_char_is_k_i;
            s1_nit  <= rx_not_in_table_i;
            s1_de   <= rx_disp_err_i;
            s1_al   <= rx_byte_is_aligned_i;
            s2_data <= s1_data;
            s2_k    <= s1_k;
            s2_nit  <= s1_nit;
            s2_de   <= s1_de;
            s2_al   <= s1_al;
        end
    end

    always_comb begin
        k_ones = '0;
        k_idx  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s2_k[i]) begin
                k_ones = k_ones + NB_W'(1);
                k_idx  = KP_W'(i);
            end
        end
    end

    // While hunting, lanes are judged relative to the word's own K lane.
    assign cmp_lane = (state == UNLOCKED) ? k_idx : k_pos;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serdes_lane_cmp u_lane_cmp (
            .data          (s2_data[8*i +: 8]),
            .is_k          (s2_k[i]),
            .not_in_table  (s2_nit[i]),
            .disp_err      (s2_de[i]),
            .is_comma_lane (cmp_lane == KP_W'(i)),
            .lane_bad      (lane_bad[i])
        );
    end

    always_comb begin
        lane_bad_n = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_bad_n = lane_bad_n + NB_W'(lane_bad[i]);
        end
    end

    assign word_bad  = |lane_bad;
    assign candidate = (k_ones == NB_W'(1)) && !word_bad;

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        k_pos_n = k_pos;
        if (!s2_al) begin
            state_n = UNLOCKED;
            good_n  = '0;
            bad_n   = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (candidate) begin
                        state_n = (LOCK_GOOD <= 1) ? LOCKED : VERIFY;
                        k_pos_n = k_idx;
                        good_n  = (LOCK_GOOD <= 1) ? '0 : GC_W'(1);
                    end
                end
                VERIFY: begin
                    if (word_bad) begin
                        state_n = UNLOCKED;
                        good_n  = '0;
                    end else if (good_cnt >= GOOD_LAST) begin
                        state_n = LOCKED;
                        good_n  = '0;
                    end else begin
                        good_n = good_cnt + GC_W'(1);
                    end
                end
                LOCKED: begin
                    if (!word_bad) begin
                        bad_n = '0;
                    end else if (bad_cnt >= BAD_LAST) begin
                        state_n = UNLOCKED;
                        bad_n   = '0;
                    end else begin
                        bad_n = bad_cnt + BC_W'(1);
                    end
                end
                default: begin
                    state_n = UNLOCKED;
                    good_n  = '0;
                    bad_n   = '0;
                end
            endcase
        end
    end

    // The word that breaks lock is still counted, but err_o is held low on it
    // so err_o only ever pulses alongside locked_o.
    assign count_en = (state == LOCKED) && word_bad;
    assign err_n    = count_en && (state_n == LOCKED);

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            k_pos    <= '0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            k_pos    <= k_pos_n;
            err_o    <= err_n;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst || cnt_reset_i) begin
            word_cnt <= '0;
            lane_cnt <= '0;
        end else if (count_en) begin
            word_cnt <= CNT_W'(sat_add(SAT_W'(word_cnt), SAT_W'(1), SAT_W'(CNT_MAX)));
            lane_cnt <= CNT_W'(sat_add(SAT_W'(lane_cnt), SAT_W'(lane_bad_n), SAT_W'(CNT_MAX)));
        end
    end

    assign locked_o       = (state == LOCKED);
    assign k_pos_o        = k_pos;
    assign word_err_cnt_o = word_cnt;
    assign lane_err_cnt_o = lane_cnt;

endmodule

// File: tb/tb_serdes_rx_checker.sv
// tb/tb_serdes_rx_checker.sv - directed and random checks of serdes_rx_checker against a word-level model
module tb_serdes_rx_checker;

    localparam int LG   = 16;
    localparam int LB   = 4;
    localparam int CMAX = 15;
    localparam int M_UNL = 0;
    localparam int M_VER = 1;
    localparam int M_LCK = 2;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [7:0]  nit;
        logic [7:0]  de;
        logic        al;
    } word_t;

    logic        rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rx_data_i = '0;
    logic [7:0]  rx_char_is_k_i = '0;
    logic [7:0]  rx_not_in_table_i = '0;
    logic [7:0]  rx_disp_err_i = '0;
    logic        rx_byte_is_aligned_i = 1'b0;
    logic        cnt_reset_i = 1'b0;
    logic        locked_o;
    logic [2:0]  k_pos_o;
    logic        err_o;
    logic [3:0]  word_err_cnt_o;
    logic [3:0]  lane_err_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    int m_state, m_good, m_bad, m_kp, m_wcnt, m_lcnt;
    bit m_err;
    word_t pipe[$];

    serdes_rx_checker #(
        .LANES(8), .LOCK_GOOD(LG), .LOSS_BAD(LB), .CNT_W(4)
    ) dut (
        .rx_clk               (rx_clk),
        .rst                  (rst),
        .rx_data_i            (rx_data_i),
        .rx_char_is_k_i       (rx_char_is_k_i),
        .rx_not_in_table_i    (rx_not_in_table_i),
        .rx_disp_err_i        (rx_disp_err_i),
        .rx_byte_is_aligned_i (rx_byte_is_aligned_i),
        .cnt_reset_i          (cnt_reset_i),
        .locked_o             (locked_o),
        .k_pos_o              (k_pos_o),
        .err_o                (err_o),
        .word_err_cnt_o       (word_err_cnt_o),
        .lane_err_cnt_o       (lane_err_cnt_o)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t clean(input int kp);
        word_t w;
        w = '0;
        w.al = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w.d[8*i +: 8] = (i == kp) ? 8'hBC : 8'h4A;
            w.k[i] = (i == kp);
        end
        return w;
    endfunction

    function automatic word_t corrupt(input word_t w0);
        word_t w;
        int l;
        int n;
        w = w0;
        n = $urandom_range(3, 1);
        for (int j = 0; j < n; j++) begin
            l = $urandom_range(7, 0);
            case ($urandom_range(3, 0))
                0: w.d[8*l +: 8] = w.d[8*l +: 8] ^ 8'($urandom_range(255, 1));
                1: w.k[l] = ~w.k[l];
                2: w.nit[l] = 1'b1;
                default: w.de[l] = 1'b1;
            endcase
        end
        return w;
    endfunction

    // Number of lanes breaking the comma rule when the comma is expected in lane kp.
    function automatic int bad_lanes(input word_t w, input int kp);
        int n;
        logic [7:0] b;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            b = w.d[8*i +: 8];
            if (b != ((i == kp) ? 8'hBC : 8'h4A) || w.k[i] != (i == kp) || w.nit[i] || w.de[i])
                n++;
        end
        return n;
    endfunction

    task automatic apply(input word_t w);
        int nb, cl;
        bit was_locked;
        was_locked = (m_state == M_LCK);
        nb = bad_lanes(w, m_kp);
        if (was_locked && nb > 0) begin
            m_wcnt = (m_wcnt + 1 > CMAX) ? CMAX : m_wcnt + 1;
            m_lcnt = (m_lcnt + nb > CMAX) ? CMAX : m_lcnt + nb;
        end
        if (!w.al) begin
            m_state = M_UNL;
            m_good = 0;
            m_bad = 0;
        end else if (m_state == M_UNL) begin
            if ($countones(w.k) == 1) begin
                cl = 0;
                for (int i = 0; i < 8; i++) if (w.k[i]) cl = i;
                if (bad_lanes(w, cl) == 0) begin
                    m_kp = cl;
                    m_good = 1;
                    m_state = M_VER;
                end
            end
        end else if (m_state == M_VER) begin
            if (nb > 0) begin
                m_state = M_UNL;
                m_good = 0;
            end else begin
                m_good++;
                if (m_good == LG) begin
                    m_state = M_LCK;
                    m_good = 0;
                end
            end
        end else begin
            if (nb > 0) begin
                m_bad++;
                if (m_bad == LB) begin
                    m_state = M_UNL;
                    m_bad = 0;
                end
            end else begin
                m_bad = 0;
            end
        end
        m_err = was_locked && nb > 0 && m_state == M_LCK;
    endtask

    task automatic step(input word_t w, input logic cr);
        rx_data_i            = w.d;
        rx_char_is_k_i       = w.k;
        rx_not_in_table_i    = w.nit;
        rx_disp_err_i        = w.de;
        rx_byte_is_aligned_i = w.al;
        cnt_reset_i          = cr;
        @(posedge rx_clk);
        #1;
        pipe.push_back(w);
        m_err = 1'b0;
        if (pipe.size() > 2) apply(pipe.pop_front());
        if (cr) begin
            m_wcnt = 0;
            m_lcnt = 0;
        end
        check("m_locked", locked_o, m_state == M_LCK);
        check("m_kpos", k_pos_o, m_kp);
        check("m_err", err_o, m_err);
        check("m_wcnt", word_err_cnt_o, m_wcnt);
        check("m_lcnt", lane_err_cnt_o, m_lcnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cnt_reset_i = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        rst = 1'b0;
        pipe.delete();
        m_state = M_UNL;
        m_good = 0;
        m_bad = 0;
        m_kp = 0;
        m_wcnt = 0;
        m_lcnt = 0;
        m_err = 1'b0;
    endtask

    initial begin
        word_t w, dk;
        int cur_kp, r;
        logic cr;

        do_reset();
        check("rst_locked", locked_o, 0);
        check("rst_kpos", k_pos_o, 0);
        check("rst_err", err_o, 0);
        check("rst_wcnt", word_err_cnt_o, 0);
        check("rst_lcnt", lane_err_cnt_o, 0);

        for (int i = 1; i <= 18; i++) begin
            step(clean(3), 1'b0);
            if (i == 17) check("lock_early", locked_o, 0);
            if (i == 18) check("lock_rise", locked_o, 1);
        end
        check("lock_kpos", k_pos_o, 3);
        check("lock_wcnt", word_err_cnt_o, 0);
        check("lock_lcnt", lane_err_cnt_o, 0);

        w = clean(3);
        w.d[7:0]   = 8'h4B;
        w.d[47:40] = 8'h4B;
        step(w, 1'b0);
        step(clean(3), 1'b0);
        step(clean(3), 1'b0);
        check("err_pulse", err_o, 1);
        step(clean(3), 1'b0);
        check("err_one_cycle", err_o, 0);
        check("two_lane_wcnt", word_err_cnt_o, 1);
        check("two_lane_lcnt", lane_err_cnt_o, 2);
        check("two_lane_locked", locked_o, 1);

        for (int i = 0; i < 4; i++) begin
            w = clean(3);
            w.nit[$urandom_range(7, 0)] = 1'b1;
            step(w, 1'b0);
        end
        step(clean(3), 1'b0);
        check("lock_held_3bad", locked_o, 1);
        step(clean(3), 1'b0);
        check("lock_lost", locked_o, 0);
        check("loss_wcnt", word_err_cnt_o, 5);
        repeat (20) step(clean(3), 1'b0);
        check("relock", locked_o, 1);

        dk = clean(3);
        dk.k[6] = 1'b1;
        w = clean(3);
        w.al = 1'b0;
        step(w, 1'b0);
        step(dk, 1'b0);
        check("align_wait", locked_o, 1);
        step(dk, 1'b0);
        check("align_unlock", locked_o, 0);
        check("align_wcnt", word_err_cnt_o, 5);
        repeat (20) step(dk, 1'b0);
        check("double_k_no_lock", locked_o, 0);
        check("double_k_kpos", k_pos_o, 3);
        repeat (18) step(clean(6), 1'b0);
        check("relock_lane6", locked_o, 1);
        check("relock_kpos6", k_pos_o, 6);

        for (int i = 0; i < 30; i++) begin
            w = clean(6);
            w.d[15:0] = 16'h0000;
            step(w, 1'b0);
            step(clean(6), 1'b0);
        end
        check("sat_wcnt", word_err_cnt_o, 15);
        check("sat_lcnt", lane_err_cnt_o, 15);
        check("sat_locked", locked_o, 1);

        w = clean(6);
        w.d[7:0] = 8'h00;
        step(w, 1'b0);
        step(clean(6), 1'b0);
        step(clean(6), 1'b1);
        check("clr_err", err_o, 1);
        check("clr_wcnt", word_err_cnt_o, 0);
        check("clr_lcnt", lane_err_cnt_o, 0);

        cur_kp = 6;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99, 0) == 0) cur_kp = $urandom_range(7, 0);
            w = clean(cur_kp);
            r = $urandom_range(99, 0);
            if (r < 8) w = corrupt(w);
            else if (r < 10) w.al = 1'b0;
            else if (r < 12) w.k[$urandom_range(7, 0)] = 1'b1;
            cr = ($urandom_range(59, 0) == 0);
            step(w, cr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
